// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: ALU operation order and
// regSelectStream slot layout.
package datapath_pkg;

  localparam int DP_BITS      = 32;
  localparam int DP_REGISTERS = 16;

  // Declaration order is the strobe priority order, ADD highest.
  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_SHR,
    OP_SHL,
    OP_ROR,
    OP_ROL,
    OP_AND,
    OP_OR,
    OP_NEGATE,
    OP_NOT,
    OP_INCPC,
    OP_NONE
  } alu_op_e;

  localparam int HI_SLOT   = DP_REGISTERS;
  localparam int LO_SLOT   = DP_REGISTERS + 1;
  localparam int ZHI_SLOT  = DP_REGISTERS + 2;
  localparam int ZLO_SLOT  = DP_REGISTERS + 3;
  localparam int PC_SLOT   = DP_REGISTERS + 4;
  localparam int MDR_SLOT  = DP_REGISTERS + 5;
  localparam int NUM_SLOTS = DP_REGISTERS + 6;

  // Re-bases a slot constant onto a register file of a different size.
  function automatic int slot_of(input int base_slot, input int regs);
    return base_slot - DP_REGISTERS + regs;
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational datapath ALU: A = RY, B = bus, 2*BITS-wide result.
// Define DATAPATH_DIV_EN to build the signed divider; otherwise DIV yields 0.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int BITS = DP_BITS
) (
  input  logic [BITS-1:0]   A,
  input  logic [BITS-1:0]   B,
  input  logic              ADD,
  input  logic              SUB,
  input  logic              MUL,
  input  logic              DIV,
  input  logic              SHR,
  input  logic              SHL,
  input  logic              ROR,
  input  logic              ROL,
  input  logic              AND,
  input  logic              OR,
  input  logic              NEGATE,
  input  logic              NOT,
  input  logic              IncPC,
  output logic [2*BITS-1:0] result
);

  localparam int SH_W = $clog2(BITS);

  alu_op_e                  op;
  logic [SH_W-1:0]          sh;
  logic signed [BITS-1:0]   a_s;
  logic signed [BITS-1:0]   b_s;
  logic signed [2*BITS-1:0] a_w;
  logic signed [2*BITS-1:0] b_w;
  logic signed [2*BITS-1:0] prod;
  logic [2*BITS-1:0]        dbl;
  logic [2*BITS-1:0]        ror_w;
  logic [2*BITS-1:0]        rol_w;

  function automatic logic [2*BITS-1:0] lo_only(input logic [BITS-1:0] v);
    return {{BITS{1'b0}}, v};
  endfunction

`ifdef DATAPATH_DIV_EN
  // Divide-by-zero returns remainder = dividend; MIN / -1 wraps to MIN, rem 0.
  function automatic logic [2*BITS-1:0] div_signed(input logic signed [BITS-1:0] n,
                                                   input logic signed [BITS-1:0] d);
    logic signed [BITS-1:0] q;
    logic signed [BITS-1:0] r;
    if (d == '0) begin
      q = '0;
      r = n;
    end else if (n == {1'b1, {(BITS-1){1'b0}}} && d == '1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction
`endif

  assign sh    = B[SH_W-1:0];
  assign a_s   = A;
  assign b_s   = B;
  assign a_w   = {{BITS{A[BITS-1]}}, A};
  assign b_w   = {{BITS{B[BITS-1]}}, B};
  assign prod  = a_w * b_w;
  assign dbl   = {A, A};
  assign ror_w = dbl >> sh;
  assign rol_w = dbl << sh;

  always_comb begin
    op = OP_NONE;
    if      (ADD)    op = OP_ADD;
    else if (SUB)    op = OP_SUB;
    else if (MUL)    op = OP_MUL;
    else if (DIV)    op = OP_DIV;
    else if (SHR)    op = OP_SHR;
    else if (SHL)    op = OP_SHL;
    else if (ROR)    op = OP_ROR;
    else if (ROL)    op = OP_ROL;
    else if (AND)    op = OP_AND;
    else if (OR)     op = OP_OR;
    else if (NEGATE) op = OP_NEGATE;
    else if (NOT)    op = OP_NOT;
    else if (IncPC)  op = OP_INCPC;
  end

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:    result = lo_only(A + B);
      OP_SUB:    result = lo_only(A - B);
      OP_MUL:    result = prod;
`ifdef DATAPATH_DIV_EN
      OP_DIV:    result = div_signed(a_s, b_s);
`else
      OP_DIV:    result = '0;
`endif
      OP_SHR:    result = lo_only(A >> sh);
      OP_SHL:    result = lo_only(A << sh);
      OP_ROR:    result = lo_only(ror_w[BITS-1:0]);
      OP_ROL:    result = lo_only(rol_w[2*BITS-1:BITS]);
      OP_AND:    result = lo_only(A & B);
      OP_OR:     result = lo_only(A | B);
      OP_NEGATE: result = lo_only(-B);
      OP_NOT:    result = lo_only(~B);
      OP_INCPC:  result = lo_only(B + 1'b1);
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: GPRs, PC, IR, MAR, MDR, HI/LO, RY and 64-bit RZ
// around one shared bus. DIV behaviour depends on DATAPATH_DIV_EN (see ALU).
module datapath
  import datapath_pkg::*;
#(
  parameter int BITS      = DP_BITS,
  parameter int REGISTERS = DP_REGISTERS
) (
  input  logic                            Clock,
  input  logic                            reset,
  input  logic [REGISTERS-1:0]            GPRin,
  input  logic                            PCin,
  input  logic                            IRin,
  input  logic                            RYin,
  input  logic                            RZin,
  input  logic                            MARin,
  input  logic                            HIin,
  input  logic                            LOin,
  input  logic                            MDRin,
  input  logic                            Read,
  input  logic                            MDRout,
  input  logic                            LOout,
  input  logic                            HIout,
  input  logic                            Zhighout,
  input  logic                            Zlowout,
  input  logic                            PCout,
  input  logic [REGISTERS-1:0]            GPRout,
  input  logic                            ADD,
  input  logic                            SUB,
  input  logic                            MUL,
  input  logic                            DIV,
  input  logic                            SHR,
  input  logic                            SHL,
  input  logic                            ROR,
  input  logic                            ROL,
  input  logic                            AND,
  input  logic                            OR,
  input  logic                            NEGATE,
  input  logic                            NOT,
  input  logic                            IncPC,
  input  logic [BITS-1:0]                 Mdatain,
  output logic [BITS*(REGISTERS+6)-1:0]   regSelectStream,
  output logic [BITS-1:0]                 bus,
  output logic [BITS-1:0]                 MARVal,
  output logic [2*BITS-1:0]               RZVal,
  output logic [BITS-1:0]                 IRVal,
  output logic [BITS-1:0]                 LOVal,
  output logic [BITS-1:0]                 HIVal
);

  localparam int HI_S  = slot_of(HI_SLOT, REGISTERS);
  localparam int LO_S  = slot_of(LO_SLOT, REGISTERS);
  localparam int ZHI_S = slot_of(ZHI_SLOT, REGISTERS);
  localparam int ZLO_S = slot_of(ZLO_SLOT, REGISTERS);
  localparam int PC_S  = slot_of(PC_SLOT, REGISTERS);
  localparam int MDR_S = slot_of(MDR_SLOT, REGISTERS);

  logic [BITS-1:0]   gpr [REGISTERS];
  logic [BITS-1:0]   pc_r;
  logic [BITS-1:0]   ir_r;
  logic [BITS-1:0]   ry_r;
  logic [BITS-1:0]   mar_r;
  logic [BITS-1:0]   mdr_r;
  logic [BITS-1:0]   hi_r;
  logic [BITS-1:0]   lo_r;
  logic [2*BITS-1:0] rz_r;
  logic [2*BITS-1:0] alu_result;
  logic [BITS-1:0]   bus_w;
  logic              gpr_hit;

  // Bus mux: lowest-index GPR wins, then the fixed special-register order.
  always_comb begin
    bus_w   = '0;
    gpr_hit = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (!gpr_hit && GPRout[i]) begin
        bus_w   = gpr[i];
        gpr_hit = 1'b1;
      end
    end
    if (!gpr_hit) begin
      if      (PCout)    bus_w = pc_r;
      else if (MDRout)   bus_w = mdr_r;
      else if (HIout)    bus_w = hi_r;
      else if (LOout)    bus_w = lo_r;
      else if (Zhighout) bus_w = rz_r[2*BITS-1:BITS];
      else if (Zlowout)  bus_w = rz_r[BITS-1:0];
    end
  end

  datapath_alu #(
    .BITS(BITS)
  ) u_alu (
    .A      (ry_r),
    .B      (bus_w),
    .ADD    (ADD),
    .SUB    (SUB),
    .MUL    (MUL),
    .DIV    (DIV),
    .SHR    (SHR),
    .SHL    (SHL),
    .ROR    (ROR),
    .ROL    (ROL),
    .AND    (AND),
    .OR     (OR),
    .NEGATE (NEGATE),
    .NOT    (NOT),
    .IncPC  (IncPC),
    .result (alu_result)
  );

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGISTERS; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < REGISTERS; i++) begin
        if (GPRin[i]) gpr[i] <= bus_w;
      end
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      pc_r  <= '0;
      ir_r  <= '0;
      ry_r  <= '0;
      mar_r <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      mdr_r <= '0;
      rz_r  <= '0;
    end else begin
      if (PCin)  pc_r  <= bus_w;
      if (IRin)  ir_r  <= bus_w;
      if (RYin)  ry_r  <= bus_w;
      if (MARin) mar_r <= bus_w;
      if (HIin)  hi_r  <= bus_w;
      if (LOin)  lo_r  <= bus_w;
      if (MDRin) mdr_r <= Read ? Mdatain : bus_w;
      if (RZin)  rz_r  <= alu_result;
    end
  end

  for (genvar k = 0; k < REGISTERS; k++) begin : g_gpr_slot
    assign regSelectStream[BITS*k +: BITS] = gpr[k];
  end
  assign regSelectStream[BITS*HI_S  +: BITS] = hi_r;
  assign regSelectStream[BITS*LO_S  +: BITS] = lo_r;
  assign regSelectStream[BITS*ZHI_S +: BITS] = rz_r[2*BITS-1:BITS];
  assign regSelectStream[BITS*ZLO_S +: BITS] = rz_r[BITS-1:0];
  assign regSelectStream[BITS*PC_S  +: BITS] = pc_r;
  assign regSelectStream[BITS*MDR_S +: BITS] = mdr_r;

  assign bus    = bus_w;
  assign MARVal = mar_r;
  assign RZVal  = rz_r;
  assign IRVal  = ir_r;
  assign LOVal  = lo_r;
  assign HIVal  = hi_r;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized ALU and
// bus-mux traffic against a behavioural model of registers, bus and ALU.
module tb_datapath;

  localparam int REGS  = 16;
  localparam int NSLOT = REGS + 6;

  // ALU strobe vector index, in priority order (bit 0 highest)
  localparam int S_ADD = 0, S_SUB = 1, S_MUL = 2, S_DIV = 3, S_SHR = 4, S_SHL = 5;
  localparam int S_ROR = 6, S_ROL = 7, S_AND = 8, S_OR = 9, S_NEG = 10, S_NOT = 11, S_INC = 12;

  logic                  Clock = 1'b0;
  logic                  reset = 1'b1;
  logic [REGS-1:0]       GPRin, GPRout;
  logic                  PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
  logic                  MDRout, LOout, HIout, Zhighout, Zlowout, PCout;
  logic [12:0]           strb;
  logic [31:0]           Mdatain;
  logic [32*NSLOT-1:0]   regSelectStream;
  logic [31:0]           bus, MARVal, IRVal, LOVal, HIVal;
  logic [63:0]           RZVal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_gpr [REGS];
  logic [31:0] m_pc, m_mdr, m_hi, m_lo, m_ry;
  logic [63:0] m_rz;

  datapath dut (
    .Clock(Clock), .reset(reset), .GPRin(GPRin), .PCin(PCin), .IRin(IRin),
    .RYin(RYin), .RZin(RZin), .MARin(MARin), .HIin(HIin), .LOin(LOin),
    .MDRin(MDRin), .Read(Read), .MDRout(MDRout), .LOout(LOout), .HIout(HIout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .GPRout(GPRout),
    .ADD(strb[S_ADD]), .SUB(strb[S_SUB]), .MUL(strb[S_MUL]), .DIV(strb[S_DIV]),
    .SHR(strb[S_SHR]), .SHL(strb[S_SHL]), .ROR(strb[S_ROR]), .ROL(strb[S_ROL]),
    .AND(strb[S_AND]), .OR(strb[S_OR]), .NEGATE(strb[S_NEG]), .NOT(strb[S_NOT]),
    .IncPC(strb[S_INC]), .Mdatain(Mdatain), .regSelectStream(regSelectStream),
    .bus(bus), .MARVal(MARVal), .RZVal(RZVal), .IRVal(IRVal), .LOVal(LOVal),
    .HIVal(HIVal)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] slot(input int k);
    return regSelectStream[32*k +: 32];
  endfunction

  function automatic logic [31:0] m_slot(input int k);
    if (k < REGS) return m_gpr[k];
    case (k - REGS)
      0: return m_hi;
      1: return m_lo;
      2: return m_rz[63:32];
      3: return m_rz[31:0];
      4: return m_pc;
      default: return m_mdr;
    endcase
  endfunction

  // Reference ALU straight from the operation rules, using wide integer arithmetic.
  function automatic logic [63:0] ref_alu(input logic [12:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
    int      idx = -1;
    int      n;
    longint  la, lb, q, r;
    logic [31:0] w;
    for (int i = 0; i < 13; i++) if (s[i] && idx < 0) idx = i;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    n  = int'(b[4:0]);
    w  = 32'h0;
    case (idx)
      S_ADD: w = a + b;
      S_SUB: w = a - b;
      S_MUL: return la * lb;
      S_DIV: begin
`ifdef DATAPATH_DIV_EN
        if (b == 32'h0) return {a, 32'h0};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
`else
        return 64'h0;
`endif
      end
      S_SHR: w = a >> n;
      S_SHL: w = a << n;
      S_ROR: w = (a >> n) | (a << (32 - n));
      S_ROL: w = (a << n) | (a >> (32 - n));
      S_AND: w = a & b;
      S_OR:  w = a | b;
      S_NEG: w = 32'h0 - b;
      S_NOT: w = ~b;
      S_INC: w = b + 32'h1;
      default: w = 32'h0;
    endcase
    return {32'h0, w};
  endfunction

  task automatic clear_ctrl();
    GPRin = '0;
    GPRout = '0;
    {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read} = '0;
    {MDRout, LOout, HIout, Zhighout, Zlowout, PCout} = '0;
    strb = '0;
    Mdatain = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < REGS; i++) m_gpr[i] = '0;
    {m_pc, m_mdr, m_hi, m_lo, m_ry} = '0;
    m_rz = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clear_ctrl();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
    m_mdr = v;
  endtask

  task automatic load_gpr(input int k, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; GPRin[k] = 1'b1;
    tick();
    m_gpr[k] = v;
  endtask

  // RY <- a while MDR takes b in the same cycle, then RZ <- ALU(RY, MDR).
  task automatic run_alu(input logic [31:0] a, input logic [31:0] b, input logic [12:0] s);
    load_mdr(a);
    MDRout = 1'b1; RYin = 1'b1; Mdatain = b; Read = 1'b1; MDRin = 1'b1;
    tick();
    m_ry = a; m_mdr = b;
    MDRout = 1'b1; strb = s; RZin = 1'b1;
    tick();
    m_rz = ref_alu(s, a, b);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NSLOT; k++) begin
      n_checks++;
      if (slot(k) !== 32'h0) begin
        n_fail++;
        $display("FAIL %s_slot%0d got %h want 0", tag, k, slot(k));
      end
    end
    n_checks++;
    if ({MARVal, IRVal, HIVal, LOVal, RZVal} !== 192'h0) begin
      n_fail++;
      $display("FAIL %s_outputs MAR=%h IR=%h HI=%h LO=%h RZ=%h want all 0",
               tag, MARVal, IRVal, HIVal, LOVal, RZVal);
    end
  endtask

  task automatic test_reset();
    clear_ctrl();
    #2;
    reset = 1'b0;
    GPRin = REGS'($urandom);
    {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read} = 9'($urandom) | 9'h1ff;
    strb = 13'($urandom);
    Mdatain = $urandom | 32'h1;
    #1;
    check_all_zero("reset_async");
    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset_held");
    clear_ctrl();
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_register_load();
    load_gpr(2, 32'h22);
    load_gpr(4, 32'h24);
    load_gpr(5, 32'h26);
    for (int k = 2; k <= 5; k++) begin
      n_checks++;
      if (slot(k) !== m_gpr[k]) begin
        n_fail++;
        $display("FAIL reg_load_R%0d got %h want %h", k, slot(k), m_gpr[k]);
      end
    end
    n_checks++;
    if (slot(NSLOT-1) !== 32'h26) begin
      n_fail++;
      $display("FAIL reg_load_MDR got %h want 00000026", slot(NSLOT-1));
    end
  endtask

  task automatic test_mul();
    GPRout[2] = 1'b1; RYin = 1'b1;
    tick();
    GPRout[4] = 1'b1; strb[S_MUL] = 1'b1; RZin = 1'b1;
    tick();
    n_checks++;
    if (RZVal !== 64'h4C8) begin
      n_fail++;
      $display("FAIL mul_rz got %h want 00000000000004c8", RZVal);
    end
    Zlowout = 1'b1; LOin = 1'b1;
    #1;
    n_checks++;
    if (bus !== 32'h4C8) begin
      n_fail++;
      $display("FAIL mul_bus_zlow got %h want 000004c8", bus);
    end
    tick();
    n_checks++;
    if (LOVal !== 32'h4C8) begin
      n_fail++;
      $display("FAIL mul_lo got %h want 000004c8", LOVal);
    end
    Zhighout = 1'b1; HIin = 1'b1;
    tick();
    n_checks++;
    if (HIVal !== 32'h0) begin
      n_fail++;
      $display("FAIL mul_hi got %h want 0", HIVal);
    end
    m_ry = 32'h22; m_rz = 64'h4C8; m_lo = 32'h4C8; m_hi = 32'h0;
  endtask

  task automatic test_fetch();
    PCout = 1'b1; strb[S_INC] = 1'b1; RZin = 1'b1; MARin = 1'b1;
    tick();
    n_checks++;
    if (MARVal !== 32'h0 || RZVal !== 64'h1) begin
      n_fail++;
      $display("FAIL fetch_incpc MAR=%h RZ=%h want MAR=0 RZ=1", MARVal, RZVal);
    end
    Zlowout = 1'b1; PCin = 1'b1;
    tick();
    n_checks++;
    if (slot(NSLOT-2) !== 32'h1) begin
      n_fail++;
      $display("FAIL fetch_pc got %h want 00000001", slot(NSLOT-2));
    end
    load_mdr(32'h4A920000);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    n_checks++;
    if (IRVal !== 32'h4A920000) begin
      n_fail++;
      $display("FAIL fetch_ir got %h want 4a920000", IRVal);
    end
    m_pc = 32'h1; m_rz = 64'h1;
  endtask

  task automatic test_div();
    logic [63:0] exp;
    run_alu(-32'sd7, 32'd2, 13'h1 << S_DIV);
`ifdef DATAPATH_DIV_EN
    exp = {32'hFFFFFFFF, 32'hFFFFFFFD};
`else
    exp = 64'h0;
`endif
    n_checks++;
    if (RZVal !== exp) begin
      n_fail++;
      $display("FAIL div_m7_by_2 got %h want %h", RZVal, exp);
    end
    run_alu(-32'sd7, 32'd0, 13'h1 << S_DIV);
`ifdef DATAPATH_DIV_EN
    exp = {32'hFFFFFFF9, 32'h0};
`else
    exp = 64'h0;
`endif
    n_checks++;
    if (RZVal !== exp) begin
      n_fail++;
      $display("FAIL div_by_zero got %h want %h", RZVal, exp);
    end
  endtask

  task automatic test_shift_rotate();
    logic [31:0] want [3];
    int          ops  [3];
    want[0] = 32'hC0000000; ops[0] = S_ROR;
    want[1] = 32'h00000003; ops[1] = S_ROL;
    want[2] = 32'h40000000; ops[2] = S_SHR;
    for (int i = 0; i < 3; i++) begin
      run_alu(32'h80000001, 32'h1, 13'h1 << ops[i]);
      n_checks++;
      if (RZVal !== {32'h0, want[i]}) begin
        n_fail++;
        $display("FAIL shift_op%0d got %h want %h", ops[i], RZVal, {32'h0, want[i]});
      end
    end
    MDRout = 1'b1; RZin = 1'b1;
    tick();
    m_rz = 64'h0;
    n_checks++;
    if (RZVal !== 64'h0) begin
      n_fail++;
      $display("FAIL no_strobe_rz got %h want 0", RZVal);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b;
    logic [12:0] s;
    for (int it = 0; it < 80; it++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) s = 13'($urandom);
      else s = 13'h1 << $urandom_range(0, 12);
      run_alu(a, b, s);
      n_checks++;
      if (RZVal !== m_rz) begin
        n_fail++;
        $display("FAIL rand_alu s=%h a=%h b=%h got %h want %h", s, a, b, RZVal, m_rz);
      end
    end
  endtask

  task automatic test_bus_priority();
    logic [31:0] exp;
    bit          found;
    run_alu($urandom, $urandom, 13'h1 << S_MUL);
    load_mdr($urandom); MDRout = 1'b1; HIin = 1'b1; tick(); m_hi = m_mdr;
    load_mdr($urandom); MDRout = 1'b1; LOin = 1'b1; tick(); m_lo = m_mdr;
    load_mdr($urandom); MDRout = 1'b1; PCin = 1'b1; tick(); m_pc = m_mdr;
    for (int k = 0; k < REGS; k++) load_gpr(k, $urandom);
    load_mdr($urandom);
    for (int k = 0; k < NSLOT; k++) begin
      n_checks++;
      if (slot(k) !== m_slot(k)) begin
        n_fail++;
        $display("FAIL stream_slot%0d got %h want %h", k, slot(k), m_slot(k));
      end
    end
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: GPRout = '0;
        1: GPRout = REGS'(1) << $urandom_range(0, REGS - 1);
        default: GPRout = REGS'($urandom);
      endcase
      {PCout, MDRout, HIout, LOout, Zhighout, Zlowout} = 6'($urandom) & 6'($urandom);
      #1;
      exp = 32'h0;
      found = 1'b0;
      for (int i = 0; i < REGS; i++) if (!found && GPRout[i]) begin exp = m_gpr[i]; found = 1'b1; end
      if (!found) begin
        if      (PCout)    exp = m_pc;
        else if (MDRout)   exp = m_mdr;
        else if (HIout)    exp = m_hi;
        else if (LOout)    exp = m_lo;
        else if (Zhighout) exp = m_rz[63:32];
        else if (Zlowout)  exp = m_rz[31:0];
      end
      n_checks++;
      if (bus !== exp) begin
        n_fail++;
        $display("FAIL bus_prio gout=%h sel=%b got %h want %h", GPRout,
                 {PCout, MDRout, HIout, LOout, Zhighout, Zlowout}, bus, exp);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_back_to_back();
    logic [31:0] old_v, new_v;
    old_v = m_mdr;
    new_v = ~old_v ^ 32'h5A5A0001;
    MDRout = 1'b1; MDRin = 1'b1; Read = 1'b1; Mdatain = new_v; GPRin[8] = 1'b1;
    #1;
    n_checks++;
    if (bus !== old_v) begin
      n_fail++;
      $display("FAIL b2b_bus got %h want %h", bus, old_v);
    end
    tick();
    m_mdr = new_v; m_gpr[8] = old_v;
    n_checks++;
    if (slot(NSLOT-1) !== new_v || slot(8) !== old_v) begin
      n_fail++;
      $display("FAIL b2b_capture MDR=%h R8=%h want MDR=%h R8=%h", slot(NSLOT-1), slot(8),
               new_v, old_v);
    end
  endtask

  task automatic test_reset_mid();
    GPRin = '1;
    {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read} = '1;
    strb = 13'h1 << S_INC;
    Mdatain = $urandom | 32'h1;
    GPRout = REGS'($urandom);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    n_checks++;
    if (bus !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_bus got %h want 0", bus);
    end
    @(posedge Clock);
    #1;
    check_all_zero("reset_mid_clocked");
    clear_ctrl();
    reset = 1'b1;
    model_clear();
    load_gpr(0, 32'hA5A5_0F0F);
    n_checks++;
    if (slot(0) !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL post_reset_R0 got %h want a5a50f0f", slot(0));
    end
  endtask

  initial begin
    clear_ctrl();
    model_clear();
    test_reset();
    test_register_load();
    test_mul();
    test_fetch();
    test_div();
    test_shift_rotate();
    test_random_alu();
    test_bus_priority();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
